// File: rtl/mini_alu_pkg.sv
// Shared constants for the mini ALU: default width and function-select codes.
// Latency: n/a (package only).
// Backpressure: n/a.
package mini_alu_pkg;

    localparam int WIDTH_DEFAULT = 6;

    localparam logic [2:0] FXN_PASS_A = 3'b000;
    localparam logic [2:0] FXN_PASS_B = 3'b001;
    localparam logic [2:0] FXN_NEG_A  = 3'b010;
    localparam logic [2:0] FXN_NEG_B  = 3'b011;
    localparam logic [2:0] FXN_SLT    = 3'b100;
    localparam logic [2:0] FXN_XNOR   = 3'b101;
    localparam logic [2:0] FXN_ADD    = 3'b110;
    localparam logic [2:0] FXN_SUB    = 3'b111;

endpackage

// File: rtl/mini_alu_addsub.sv
// Shared adder: sum = a + (invert_b ? ~b : b) + cin, with signed overflow flag.
// Latency: combinational.
// Backpressure: none.
module mini_alu_addsub #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = invert_b ? ~b : b;
    assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, cin};

    // Overflow: both addends share a sign that differs from the result sign.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mini_alu.sv
// Registered eight-function ALU (pass, negate, signed less-than, XNOR, add, subtract).
// Latency: 1 cycle from in_valid to out_valid; X holds when no new op is issued.
// Backpressure: none; accepts a new operation every cycle.
module mini_alu
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fxn,
    input  logic             in_valid,
    output logic [WIDTH-1:0] X,
    output logic             out_valid
);

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_inv;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             slt;
    logic [WIDTH-1:0] result;

    // Operand mux: negate is 0 + ~op + 1; compare and subtract are A + ~B + 1.
    always_comb begin
        add_a   = A;
        add_b   = B;
        add_inv = 1'b0;
        add_cin = 1'b0;
        case (fxn)
            FXN_NEG_A: begin
                add_a   = '0;
                add_b   = A;
                add_inv = 1'b1;
                add_cin = 1'b1;
            end
            FXN_NEG_B: begin
                add_a   = '0;
                add_b   = B;
                add_inv = 1'b1;
                add_cin = 1'b1;
            end
            FXN_SLT, FXN_SUB: begin
                add_inv = 1'b1;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    mini_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (add_a),
        .b        (add_b),
        .invert_b (add_inv),
        .cin      (add_cin),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // A - B is negative exactly when the sign bit disagrees with overflow.
    assign slt = add_sum[WIDTH-1] ^ add_ovf;

    always_comb begin
        result = '0;
        case (fxn)
            FXN_PASS_A: result = A;
            FXN_PASS_B: result = B;
            FXN_SLT:    result = {{(WIDTH-1){1'b0}}, slt};
            FXN_XNOR:   result = ~(A ^ B);
            default:    result = add_sum;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            X         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                X <= result;
            end
        end
    end

endmodule

// File: tb/tb_mini_alu.sv
// Testbench for mini_alu: vector table plus random ops, scoreboard-checked,
// with valid/hold tracking and an asynchronous mid-stream reset sequence.
module tb_mini_alu;

    logic       clk;
    logic       reset;
    logic [5:0] A;
    logic [5:0] B;
    logic [2:0] fxn;
    logic       in_valid;
    logic [5:0] X;
    logic       out_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] f;
        logic [5:0] x;
    } vec_t;

    vec_t       vecs[18];
    logic [5:0] exp_q[$];
    logic [5:0] last_x;
    logic       exp_vld;
    logic [5:0] exp_x;

    mini_alu #(.WIDTH(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .fxn       (fxn),
        .in_valid  (in_valid),
        .X         (X),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model(input logic [5:0] a, input logic [5:0] b,
                                         input logic [2:0] f);
        logic [5:0] r;
        case (f)
            3'd0: r = a;
            3'd1: r = b;
            3'd2: r = 6'd0 - a;
            3'd3: r = 6'd0 - b;
            3'd4: r = ($signed(a) < $signed(b)) ? 6'd1 : 6'd0;
            3'd5: r = ~(a ^ b);
            3'd6: r = a + b;
            default: r = a - b;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f,
                         input logic [5:0] x);
        @(negedge clk);
        A        = a;
        B        = b;
        fxn      = f;
        in_valid = 1'b1;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = 6'h2a;
            B        = 6'h15;
            fxn      = 3'd6;
        end
    endtask

    // Monitor: out_valid must follow the previous edge's in_valid; X pops or holds.
    always begin
        @(posedge clk);
        exp_vld = in_valid && !reset;
        #2;
        check("out_valid", {5'd0, out_valid}, {5'd0, exp_vld});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got X=%b with empty scoreboard", X);
            end else begin
                exp_x = exp_q.pop_front();
                check("result", X, exp_x);
                last_x = exp_x;
            end
        end else begin
            check("hold", X, last_x);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'b111000, 6'b111000, 3'b000, 6'b111000};
        vecs[1]  = '{6'b111000, 6'b111000, 3'b001, 6'b111000};
        vecs[2]  = '{6'b111000, 6'b111000, 3'b010, 6'b001000};
        vecs[3]  = '{6'b000000, 6'b111000, 3'b010, 6'b000000};
        vecs[4]  = '{6'b111000, 6'b100000, 3'b011, 6'b100000};
        vecs[5]  = '{6'b100000, 6'b000001, 3'b010, 6'b100000};
        vecs[6]  = '{6'b100101, 6'b101111, 3'b100, 6'b000001};
        vecs[7]  = '{6'b010101, 6'b101111, 3'b100, 6'b000000};
        vecs[8]  = '{6'b110101, 6'b001111, 3'b100, 6'b000001};
        vecs[9]  = '{6'b111111, 6'b111111, 3'b100, 6'b000000};
        vecs[10] = '{6'b000101, 6'b001111, 3'b101, 6'b110101};
        vecs[11] = '{6'b000000, 6'b000000, 3'b101, 6'b111111};
        vecs[12] = '{6'b111111, 6'b111111, 3'b110, 6'b111110};
        vecs[13] = '{6'b000101, 6'b001111, 3'b110, 6'b010100};
        vecs[14] = '{6'b000101, 6'b001111, 3'b111, 6'b110110};
        vecs[15] = '{6'b111000, 6'b111000, 3'b111, 6'b000000};
        vecs[16] = '{6'b101111, 6'b010101, 3'b100, 6'b000001};
        vecs[17] = '{6'b011111, 6'b100000, 3'b111, 6'b111111};

        last_x   = 6'd0;
        A        = 6'd0;
        B        = 6'd0;
        fxn      = 3'd0;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("reset_X", X, 6'd0);
        check("reset_out_valid", {5'd0, out_valid}, 6'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Back-to-back table vectors, then a gap to observe hold.
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].x);
        end
        idle(3);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] ra;
            logic [5:0] rb;
            logic [2:0] rf;
            ra = 6'($urandom_range(0, 63));
            rb = 6'($urandom_range(0, 63));
            rf = 3'($urandom_range(0, 7));
            issue(ra, rb, rf, model(ra, rb, rf));
            if ((i % 7) == 3) idle(2);
        end
        idle(2);

        // Asynchronous reset while a result is showing and a new op is pending.
        issue(6'b010011, 6'b000110, 3'b110, 6'b011001);
        issue(6'b001001, 6'b000010, 3'b000, 6'b001001);
        @(posedge clk);
        #4;
        reset = 1'b1;
        exp_q.delete();
        last_x = 6'd0;
        #1;
        check("async_reset_X", X, 6'd0);
        check("async_reset_out_valid", {5'd0, out_valid}, 6'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        idle(2);

        issue(6'b000011, 6'b000100, 3'b111, 6'b111111);
        issue(6'b100000, 6'b000000, 3'b011, 6'b000000);
        idle(3);

        check("scoreboard_drained", 6'(exp_q.size()), 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
